field_update_scheduler: RTL and testbench
=========================================

// Module: field_update_scheduler
// PURPOSE
// Owns the 20x10 Tetris playfield seen by the VGA display path. Arbitrates cell writes from two
// requesters (game engine, effects), sequences multi-cycle line-clear row shifts into a shadow field,
// and publishes shadow -> oFIELD only at a vertical-sync boundary so the display never tears mid-frame.
// oFIELD drives the field input of the VGA controller; iVS is the sync generator's VS, same clock.
// PARAMETERS
// ROWS  20  playfield rows; row 0 = top
// COLS  10  playfield columns
// CBITS 2   bits per cell; cell (r,c) at bits [CBITS*(r*COLS+c) +: CBITS]; FW = ROWS*COLS*CBITS = 400
// PORTS
// iVGA_CLK      in  1   pixel clock; only clock
// iRST_n        in  1   asynchronous, active-low reset
// iVS           in  1   vertical sync, active low, synchronous to iVGA_CLK
// iREQ0/iREQ1   in  1   cell-write request, held with data until granted
// iROW0/iROW1   in  5   target row
// iCOL0/iCOL1   in  4   target column
// iVAL0/iVAL1   in  2   cell value
// oGNT0/oGNT1   out 1   combinational grant; write lands at the clock edge where GNT=1
// iSHIFT        in  1   pulse: clear row iSHIFT_ROW, shift rows above it down by one
// iSHIFT_ROW    in  5   row to clear
// iCOMMIT       in  1   pulse: publish shadow at next VS falling edge
// oBUSY         out 1   1 while in SHIFT or COPY
// oPEND         out 1   commit requested, not yet published
// oFRAME_DONE   out 1   one-cycle pulse on the cycle after oFIELD updates
// oERR          out 1   one-cycle pulse: out-of-range write/shift dropped
// oFIELD        out 400 published playfield
// BEHAVIOUR
// - Reset: shadow=0, oFIELD=0, state IDLE, oPEND=0, vs_flag=0, vs_d=1, rr ptr favours req0,
//   oGNTx=0, oBUSY=0, oFRAME_DONE=0, oERR=0. Reset mid-SHIFT/COPY aborts with no partial publish.
// - vs_d registers iVS. Falling edge (vs_d=1, iVS=0) sets vs_flag; rising edge clears it; COPY clears it.
// - States: IDLE, SHIFT, COPY. Priority each IDLE cycle: COPY > SHIFT start > writes.
// - IDLE->COPY when oPEND & vs_flag. COPY (1 cycle): oFIELD<=shadow, oPEND<=0, vs_flag<=0;
//   next cycle oFRAME_DONE=1, state IDLE.
// - IDLE->SHIFT on iSHIFT (if COPY not taken): cur<=iSHIFT_ROW. Each SHIFT cycle: row[cur]<=row[cur-1]
//   (row 0 <= 0), cur<=cur-1; exits to IDLE after the cycle handling row 0 (iSHIFT_ROW+1 cycles).
//   iSHIFT_ROW>=ROWS: ignored, oERR pulse, stay IDLE. iSHIFT while busy: ignored (caller polls oBUSY).
// - If COPY wins over a same-cycle iSHIFT, that iSHIFT is lost; callers must issue iSHIFT only when
//   oBUSY=0 and oPEND=0, or re-issue after oFRAME_DONE.
// - Writes: granted only in IDLE with no COPY/SHIFT starting that cycle. One grant/cycle. Sole
//   requester wins; both -> rr pointer chooses, pointer flips to the other after each contested grant.
// - Granted write with row>=ROWS or col>=COLS: no shadow change, oERR pulse; still counts as granted.
// - iCOMMIT in any state sets oPEND (idempotent). If VS edge passes during SHIFT, vs_flag holds and
//   COPY runs right after SHIFT ends (shift <=20 cycles << 2-line VS pulse); if VS rises first, wait
//   for next frame. Writes granted in the cycle before COPY are included.
// - oFIELD changes only in COPY cycles.
// TESTING
// - Reset, idle 2 frames -> oFIELD=0, oPEND=0, no grants, no oFRAME_DONE.
// - REQ0 (r=19,c=0,v=2) + iCOMMIT, pulse iVS low -> oGNT0 1 cycle; oFIELD[381:380]=2 after VS fall; one oFRAME_DONE.
// - REQ0,REQ1 held 4 cycles -> grants alternate 0,1,0,1; both cells in shadow.
// - Fill row 18, mark (17,3)=1, iSHIFT row 18 -> oBUSY 19 cycles; after commit row18 col3=1, row0=0.
// - iCOMMIT + VS falling mid-SHIFT -> COPY cycle immediately after SHIFT exit; oFIELD shows shifted field.
// - Write r=20 -> granted, oERR pulse, shadow unchanged; iRST_n low during SHIFT -> all outputs reset values.

Source files
------------

// File: rtl/field_update_scheduler.sv
// Owns the published Tetris playfield: arbitrates cell writes, runs line-clear row shifts into a
// shadow copy, and publishes shadow -> oFIELD only on a vertical-sync falling edge.
module field_update_scheduler #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int CBITS = 2
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        iVS,
  input  logic                        iREQ0,
  input  logic                        iREQ1,
  input  logic [4:0]                  iROW0,
  input  logic [4:0]                  iROW1,
  input  logic [3:0]                  iCOL0,
  input  logic [3:0]                  iCOL1,
  input  logic [CBITS-1:0]            iVAL0,
  input  logic [CBITS-1:0]            iVAL1,
  output logic                        oGNT0,
  output logic                        oGNT1,
  input  logic                        iSHIFT,
  input  logic [4:0]                  iSHIFT_ROW,
  input  logic                        iCOMMIT,
  output logic                        oBUSY,
  output logic                        oPEND,
  output logic                        oFRAME_DONE,
  output logic                        oERR,
  output logic [ROWS*COLS*CBITS-1:0]  oFIELD,
  output logic [1:0]                  oSTATE
);

  localparam int FW = ROWS * COLS * CBITS;
  localparam int RW = COLS * CBITS;
  localparam logic [4:0] ROW_LIM = 5'(ROWS);
  localparam logic [3:0] COL_LIM = 4'(COLS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_COPY  = 2'd2;

  logic [1:0]       state;
  logic [4:0]       cur;
  logic             vs_d, vs_flag, rr;
  logic [FW-1:0]    shadow;
  logic             idle, copy_go, shift_req, shift_ok, wr_ok, wr_en, wr_in_range, err_next;
  logic [4:0]       wr_row;
  logic [3:0]       wr_col;
  logic [CBITS-1:0] wr_val;
  int               wr_idx, src_idx;
  logic [RW-1:0]    shift_src;

  // Request/grant: a requester holds iREQx with its row/col/value stable until it sees oGNTx=1;
  // the write lands on that same clock edge, so the requester may change data on the next cycle.
  always_comb begin
    idle      = (state == S_IDLE);
    copy_go   = idle & oPEND & vs_flag;
    shift_req = idle & ~copy_go & iSHIFT;
    shift_ok  = shift_req & (iSHIFT_ROW < ROW_LIM);
    wr_ok     = iRST_n & idle & ~copy_go & ~shift_ok;
    oGNT0     = wr_ok & iREQ0 & (~iREQ1 | ~rr);
    oGNT1     = wr_ok & iREQ1 & (~iREQ0 | rr);
    wr_en     = oGNT0 | oGNT1;
    wr_row    = oGNT1 ? iROW1 : iROW0;
    wr_col    = oGNT1 ? iCOL1 : iCOL0;
    wr_val    = oGNT1 ? iVAL1 : iVAL0;
    wr_in_range = (wr_row < ROW_LIM) && (wr_col < COL_LIM);
    wr_idx    = (int'(wr_row) * COLS + int'(wr_col)) * CBITS;
    err_next  = (shift_req & ~shift_ok) | (wr_en & ~wr_in_range);
    src_idx   = (cur == 5'd0) ? 0 : int'(cur) - 1;
    shift_src = (cur == 5'd0) ? '0 : shadow[src_idx*RW +: RW];
  end

  assign oBUSY  = (state == S_SHIFT) | (state == S_COPY);
  assign oSTATE = state;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= S_IDLE;
      cur   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (copy_go) begin
            state <= S_COPY;
          end else if (shift_ok) begin
            state <= S_SHIFT;
            cur   <= iSHIFT_ROW;
          end
        end
        S_SHIFT: begin
          if (cur == 5'd0) state <= S_IDLE;
          else             cur   <= cur - 5'd1;
        end
        S_COPY:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // One row moves per SHIFT cycle, walking upward from the cleared row; row 0 is refilled empty.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      shadow <= '0;
    end else if (state == S_SHIFT) begin
      shadow[int'(cur)*RW +: RW] <= shift_src;
    end else if (wr_en && wr_in_range) begin
      shadow[wr_idx +: CBITS] <= wr_val;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oFIELD      <= '0;
      oPEND       <= 1'b0;
      vs_d        <= 1'b1;
      vs_flag     <= 1'b0;
      rr          <= 1'b0;
      oERR        <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      if (state == S_COPY) oFIELD <= shadow;
      oPEND <= iCOMMIT | (oPEND & (state != S_COPY));
      vs_d  <= iVS;
      // A falling edge seen during SHIFT stays latched so COPY follows the shift in the same frame.
      if (state == S_COPY)     vs_flag <= 1'b0;
      else if (vs_d && !iVS)   vs_flag <= 1'b1;
      else if (!vs_d && iVS)   vs_flag <= 1'b0;
      if (oGNT0 && iREQ1)      rr <= 1'b1;
      else if (oGNT1 && iREQ0) rr <= 1'b0;
      oERR        <= err_next;
      oFRAME_DONE <= (state == S_COPY);
    end
  end

endmodule

// File: tb/tb_field_update_scheduler.sv
// Bench for field_update_scheduler: bench-side playfield model feeds an expected-publish queue
// and an expected-grant queue; each scenario task compares DUT outputs against them.
module tb_field_update_scheduler;

  localparam int ROWS = 20, COLS = 10, CBITS = 2;
  localparam int FW = ROWS * COLS * CBITS;
  localparam int RW = COLS * CBITS;

  logic              clk = 1'b0;
  logic              iRST_n, iVS, iREQ0, iREQ1, iSHIFT, iCOMMIT;
  logic [4:0]        iROW0, iROW1, iSHIFT_ROW;
  logic [3:0]        iCOL0, iCOL1;
  logic [CBITS-1:0]  iVAL0, iVAL1;
  logic              oGNT0, oGNT1, oBUSY, oPEND, oFRAME_DONE, oERR;
  logic [FW-1:0]     oFIELD;
  logic [1:0]        oSTATE;

  always #5 clk = ~clk;

  field_update_scheduler #(.ROWS(ROWS), .COLS(COLS), .CBITS(CBITS)) dut (
    .iVGA_CLK(clk), .iRST_n(iRST_n), .iVS(iVS),
    .iREQ0(iREQ0), .iREQ1(iREQ1), .iROW0(iROW0), .iROW1(iROW1),
    .iCOL0(iCOL0), .iCOL1(iCOL1), .iVAL0(iVAL0), .iVAL1(iVAL1),
    .oGNT0(oGNT0), .oGNT1(oGNT1), .iSHIFT(iSHIFT), .iSHIFT_ROW(iSHIFT_ROW),
    .iCOMMIT(iCOMMIT), .oBUSY(oBUSY), .oPEND(oPEND), .oFRAME_DONE(oFRAME_DONE),
    .oERR(oERR), .oFIELD(oFIELD), .oSTATE(oSTATE)
  );

  int            n_checks = 0;
  int            n_fail = 0;
  logic [FW-1:0] m_field;
  logic [FW-1:0] m_pub;
  logic          m_rr;
  logic [FW-1:0] exp_q[$];
  logic [1:0]    gexp_q[$];

  function automatic logic [FW-1:0] set_cell(input logic [FW-1:0] f, input int r, input int c,
                                             input logic [CBITS-1:0] v);
    if (r < ROWS && c < COLS) f[(r*COLS+c)*CBITS +: CBITS] = v;
    return f;
  endfunction

  function automatic logic [FW-1:0] shift_rows(input logic [FW-1:0] f, input int row);
    for (int r = row; r >= 1; r--) f[r*RW +: RW] = f[(r-1)*RW +: RW];
    f[0 +: RW] = '0;
    return f;
  endfunction

  task automatic idle_inputs();
    iVS = 1'b1; iREQ0 = 1'b0; iREQ1 = 1'b0; iSHIFT = 1'b0; iCOMMIT = 1'b0;
    iROW0 = '0; iROW1 = '0; iCOL0 = '0; iCOL1 = '0; iVAL0 = '0; iVAL1 = '0; iSHIFT_ROW = '0;
  endtask

  task automatic write0(input int r, input int c, input logic [CBITS-1:0] v, output bit g);
    @(negedge clk);
    iREQ0 = 1'b1; iROW0 = 5'(r); iCOL0 = 4'(c); iVAL0 = v;
    #1 g = oGNT0;
  endtask

  task automatic release_reqs();
    @(negedge clk);
    iREQ0 = 1'b0; iREQ1 = 1'b0;
  endtask

  task automatic run_publish(output bit done, output logic [FW-1:0] fld, output int pulses);
    done = 1'b0; fld = '0; pulses = 0;
    @(negedge clk); iCOMMIT = 1'b1;
    @(negedge clk); iCOMMIT = 1'b0; iVS = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 3) iVS = 1'b1;
      if (oFRAME_DONE === 1'b1) begin
        if (pulses == 0) fld = oFIELD;
        pulses++;
        done = 1'b1;
      end
    end
  endtask

  task automatic check_publish(input string name, input bit done, input logic [FW-1:0] fld);
    logic [FW-1:0] e;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s_done: got oFRAME_DONE never, expected a pulse", name);
    end
    n_checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (fld !== e) begin
      n_fail++; $display("FAIL %s_field: got %h expected %h", name, fld, e);
    end
    m_pub = e;
  endtask

  task automatic test_reset();
    bit saw_fd, saw_gnt, bad_field;
    idle_inputs();
    iRST_n = 1'b0;
    iREQ0 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({oGNT0, oGNT1, oBUSY, oPEND, oERR, oFRAME_DONE} !== 6'b0 || oFIELD !== '0 || oSTATE !== 2'd0) begin
      n_fail++; $display("FAIL reset_outputs: got gnt=%b%b busy=%b pend=%b err=%b fd=%b state=%0d expected all 0",
                         oGNT0, oGNT1, oBUSY, oPEND, oERR, oFRAME_DONE, oSTATE);
    end
    @(negedge clk); iREQ0 = 1'b0; iRST_n = 1'b1;
    m_field = '0; m_pub = '0; m_rr = 1'b0;
    saw_fd = 0; saw_gnt = 0; bad_field = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        iVS = (i < 5) ? 1'b0 : 1'b1;
        #1;
        if (oFRAME_DONE) saw_fd = 1;
        if (oGNT0 || oGNT1) saw_gnt = 1;
        if (oFIELD !== '0) bad_field = 1;
      end
    end
    n_checks++;
    if (saw_fd) begin n_fail++; $display("FAIL idle_frame_done: got pulse expected none"); end
    n_checks++;
    if (saw_gnt) begin n_fail++; $display("FAIL idle_grant: got grant expected none"); end
    n_checks++;
    if (bad_field || oPEND !== 1'b0) begin
      n_fail++; $display("FAIL idle_field: got field_changed=%b pend=%b expected 0 0", bad_field, oPEND);
    end
  endtask

  task automatic test_single_write();
    bit done; logic [FW-1:0] fld; int pulses;
    @(negedge clk);
    iREQ0 = 1'b1; iROW0 = 5'd19; iCOL0 = 4'd0; iVAL0 = 2'd2; iCOMMIT = 1'b1;
    #1;
    n_checks++;
    if ({oGNT1, oGNT0} !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: got %b expected 01", {oGNT1, oGNT0});
    end
    m_field = set_cell(m_field, 19, 0, 2'd2);
    exp_q.push_back(m_field);
    @(negedge clk); iREQ0 = 1'b0; iCOMMIT = 1'b0;
    #1;
    n_checks++;
    if (oGNT0 !== 1'b0 || oPEND !== 1'b1) begin
      n_fail++; $display("FAIL single_after: got gnt0=%b pend=%b expected 0 1", oGNT0, oPEND);
    end
    run_publish(done, fld, pulses);
    check_publish("single", done, fld);
    n_checks++;
    if (fld[381:380] !== 2'd2 || pulses != 1 || oPEND !== 1'b0) begin
      n_fail++; $display("FAIL single_cell: got cell=%0d pulses=%0d pend=%b expected 2 1 0",
                         fld[381:380], pulses, oPEND);
    end
  endtask

  task automatic test_round_robin();
    bit done; logic [FW-1:0] fld; int pulses;
    int c0, c1;
    logic [1:0] e, got;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      iREQ0 = 1'b1; iROW0 = 5'd2; iCOL0 = 4'(c0); iVAL0 = 2'd1;
      iREQ1 = 1'b1; iROW1 = 5'd3; iCOL1 = 4'(c1); iVAL1 = 2'd3;
      gexp_q.push_back(m_rr ? 2'b10 : 2'b01);
      #1 got = {oGNT1, oGNT0};
      e = gexp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", k, got, e);
      end
      if (e == 2'b01) begin m_field = set_cell(m_field, 2, c0, 2'd1); c0++; end
      else            begin m_field = set_cell(m_field, 3, c1, 2'd3); c1++; end
      m_rr = ~m_rr;
    end
    release_reqs();
    exp_q.push_back(m_field);
    run_publish(done, fld, pulses);
    check_publish("rr", done, fld);
  endtask

  task automatic test_shift();
    bit done, g; logic [FW-1:0] fld; int pulses, gok, busy_n;
    gok = 0;
    for (int c = 0; c < COLS; c++) begin
      write0(18, c, 2'((c % 3) + 1), g);
      if (g) gok++;
      m_field = set_cell(m_field, 18, c, 2'((c % 3) + 1));
    end
    write0(17, 3, 2'd1, g);
    if (g) gok++;
    m_field = set_cell(m_field, 17, 3, 2'd1);
    n_checks++;
    if (gok != 11) begin n_fail++; $display("FAIL fill_grants: got %0d expected 11", gok); end
    @(negedge clk);
    iREQ0 = 1'b0; iSHIFT = 1'b1; iSHIFT_ROW = 5'd18;
    @(negedge clk);
    iSHIFT = 1'b0;
    busy_n = 0;
    while (oBUSY && busy_n < 40) begin busy_n++; @(negedge clk); end
    n_checks++;
    if (busy_n != 19) begin n_fail++; $display("FAIL shift_busy: got %0d cycles expected 19", busy_n); end
    m_field = shift_rows(m_field, 18);
    exp_q.push_back(m_field);
    run_publish(done, fld, pulses);
    check_publish("shift", done, fld);
    n_checks++;
    if (fld[367:366] !== 2'd1 || fld[RW-1:0] !== '0) begin
      n_fail++; $display("FAIL shift_cells: got r18c3=%0d row0=%h expected 1 0", fld[367:366], fld[RW-1:0]);
    end
  endtask

  task automatic test_shift_commit_vs();
    bit g, g2, moved; int busy_n, lat; logic [FW-1:0] e;
    write0(0, 0, 2'd1, g);
    write0(10, 5, 2'd3, g2);
    m_field = set_cell(m_field, 0, 0, 2'd1);
    m_field = set_cell(m_field, 10, 5, 2'd3);
    n_checks++;
    if (!(g && g2)) begin n_fail++; $display("FAIL scv_grants: got %b%b expected 11", g, g2); end
    @(negedge clk);
    iREQ0 = 1'b0; iSHIFT = 1'b1; iSHIFT_ROW = 5'd10; iCOMMIT = 1'b1;
    @(negedge clk);
    iSHIFT = 1'b0; iCOMMIT = 1'b0;
    m_field = shift_rows(m_field, 10);
    exp_q.push_back(m_field);
    repeat (3) @(negedge clk);
    iVS = 1'b0;
    busy_n = 0; moved = 0;
    while (oBUSY && busy_n < 40) begin
      if (oFIELD !== m_pub) moved = 1;
      busy_n++; @(negedge clk);
    end
    if (oFIELD !== m_pub) moved = 1;
    n_checks++;
    if (moved) begin n_fail++; $display("FAIL scv_field_stable: got change during shift expected none"); end
    lat = 0;
    while (!oFRAME_DONE && lat < 10) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL scv_latency: got %0d cycles expected 2", lat); end
    n_checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (oFIELD !== e || oPEND !== 1'b0) begin
      n_fail++; $display("FAIL scv_field: got %h pend=%b expected %h 0", oFIELD, oPEND, e);
    end
    m_pub = e;
    iVS = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_errors();
    bit done; logic [FW-1:0] fld; int pulses;
    @(negedge clk);
    iREQ0 = 1'b1; iROW0 = 5'd20; iCOL0 = 4'd0; iVAL0 = 2'd3;
    #1;
    n_checks++;
    if (oGNT0 !== 1'b1) begin n_fail++; $display("FAIL err_row_grant: got %b expected 1", oGNT0); end
    @(negedge clk);
    iREQ0 = 1'b0;
    iREQ1 = 1'b1; iROW1 = 5'd5; iCOL1 = 4'd10; iVAL1 = 2'd2;
    #1;
    n_checks++;
    if (oERR !== 1'b1 || oGNT1 !== 1'b1) begin
      n_fail++; $display("FAIL err_row_pulse: got err=%b gnt1=%b expected 1 1", oERR, oGNT1);
    end
    @(negedge clk);
    iREQ1 = 1'b0;
    #1;
    n_checks++;
    if (oERR !== 1'b1) begin n_fail++; $display("FAIL err_col_pulse: got %b expected 1", oERR); end
    @(negedge clk);
    #1;
    n_checks++;
    if (oERR !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", oERR); end
    iSHIFT = 1'b1; iSHIFT_ROW = 5'd20;
    @(negedge clk);
    iSHIFT = 1'b0;
    #1;
    n_checks++;
    if (oERR !== 1'b1 || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL err_shift: got err=%b busy=%b expected 1 0", oERR, oBUSY);
    end
    exp_q.push_back(m_field);
    run_publish(done, fld, pulses);
    check_publish("err", done, fld);
  endtask

  task automatic test_reset_mid_shift();
    bit done, g; logic [FW-1:0] fld; int pulses;
    write0(19, 9, 2'd3, g);
    @(negedge clk);
    iREQ0 = 1'b0; iSHIFT = 1'b1; iSHIFT_ROW = 5'd15; iCOMMIT = 1'b1;
    @(negedge clk);
    iSHIFT = 1'b0; iCOMMIT = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (oBUSY !== 1'b1 || oPEND !== 1'b1 || !g) begin
      n_fail++; $display("FAIL rst_pre: got busy=%b pend=%b gnt=%b expected 1 1 1", oBUSY, oPEND, g);
    end
    iRST_n = 1'b0;
    #1;
    n_checks++;
    if ({oGNT0, oGNT1, oBUSY, oPEND, oERR, oFRAME_DONE} !== 6'b0 || oFIELD !== '0) begin
      n_fail++; $display("FAIL rst_mid_shift: got gnt=%b%b busy=%b pend=%b err=%b fd=%b field_nonzero=%b expected all 0",
                         oGNT0, oGNT1, oBUSY, oPEND, oERR, oFRAME_DONE, (oFIELD !== '0));
    end
    @(negedge clk);
    iRST_n = 1'b1;
    m_field = '0; m_rr = 1'b0;
    exp_q.push_back(m_field);
    run_publish(done, fld, pulses);
    check_publish("rst_publish", done, fld);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_shift();
    test_shift_commit_vs();
    test_errors();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
